// File: rtl/uart_num_tokenizer.sv
// Streaming ASCII-decimal tokenizer: turns space-separated signed integers,
// terminated by '\n', into saturated DATA_W-bit tokens with index and line framing.
module uart_num_tokenizer #(
   parameter int DATA_W     = 8,
   parameter int MAX_DIGITS = 5,
   parameter int MAX_TOKENS = 32,
   parameter int SIGNED_EN  = 1,
   localparam int IDX_W     = (MAX_TOKENS > 1) ? $clog2(MAX_TOKENS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [DATA_W-1:0] tok_value,
   output logic [IDX_W-1:0]  tok_index,
   output logic              tok_last,
   output logic              tok_valid,
   input  logic              tok_ready,
   output logic              line_done,
   output logic              err_range,
   output logic              err_char,
   output logic              err_ovr
);

   // Accumulator is one bit wider than the output so saturation never wraps.
   localparam int ACC_W = DATA_W + 1;
   localparam int WW    = ACC_W + 4;
   localparam int DC_W  = $clog2(MAX_DIGITS + 1);

   localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] MAX_V = (SIGNED_EN != 0) ? {1'b0, {(DATA_W-1){1'b1}}}
                                                         : {DATA_W{1'b1}};
   localparam logic [ACC_W-1:0]  POS_MAX = {1'b0, MAX_V};
   localparam logic [ACC_W-1:0]  NEG_MAG = {1'b0, MIN_V};
   localparam logic [ACC_W-1:0]  LIMIT   = (SIGNED_EN != 0) ? NEG_MAG + ACC_W'(1)
                                                            : {1'b1, {DATA_W{1'b0}}};
   localparam logic [IDX_W:0]    IDX_LIM = (IDX_W+1)'(MAX_TOKENS);
   localparam logic [DC_W-1:0]   DC_LIM  = DC_W'(MAX_DIGITS);

   typedef enum logic [1:0] {S_IDLE, S_SIGN, S_DIGIT, S_SKIP} state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [DC_W-1:0]  dcnt;
   logic             neg;
   logic [IDX_W:0]   idx;

   logic             is_digit, is_delim, is_nl, is_minus;
   logic [3:0]       digit;
   logic [DATA_W:0]  clamp_res;

   // acc*10+d, saturated at LIMIT; computed wide enough that the product cannot wrap.
   function automatic logic [ACC_W-1:0] acc_step(input logic [ACC_W-1:0] acc_in,
                                                 input logic [3:0] d);
      logic [WW-1:0] wide;
      wide = WW'(acc_in) * WW'(10) + WW'(d);
      if (wide > WW'(LIMIT)) return LIMIT;
      return wide[ACC_W-1:0];
   endfunction

   // Applies the sign and clamps to the output range; MSB of the result flags a clamp.
   function automatic logic [DATA_W:0] clamp_val(input logic neg_in,
                                                 input logic [ACC_W-1:0] mag);
      logic signed [ACC_W-1:0] negated;
      negated = -$signed(mag);
      if (neg_in) begin
         if (mag > NEG_MAG) return {1'b1, MIN_V};
         return {1'b0, negated[DATA_W-1:0]};
      end
      if (mag > POS_MAX) return {1'b1, MAX_V};
      return {1'b0, mag[DATA_W-1:0]};
   endfunction

   // Byte classification and the value that would be emitted if the token ended now.
   always_comb begin
      is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
      is_delim  = (rx_data == 8'h20) || (rx_data == 8'h0D);
      is_nl     = (rx_data == 8'h0A);
      is_minus  = (rx_data == 8'h2D);
      digit     = rx_data[3:0];
      clamp_res = clamp_val(neg, acc);
   end

   // Parser FSM, token index tracking and the single-entry output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         acc       <= '0;
         dcnt      <= '0;
         neg       <= 1'b0;
         idx       <= '0;
         tok_value <= '0;
         tok_index <= '0;
         tok_last  <= 1'b0;
         tok_valid <= 1'b0;
         line_done <= 1'b0;
         err_range <= 1'b0;
         err_char  <= 1'b0;
         err_ovr   <= 1'b0;
      end else begin
         line_done <= 1'b0;
         err_range <= 1'b0;
         err_char  <= 1'b0;
         err_ovr   <= 1'b0;
         if (clear) begin
            state     <= S_IDLE;
            acc       <= '0;
            dcnt      <= '0;
            neg       <= 1'b0;
            idx       <= '0;
            tok_value <= '0;
            tok_index <= '0;
            tok_last  <= 1'b0;
            tok_valid <= 1'b0;
         end else begin
            if (tok_valid && tok_ready) begin
               tok_valid <= 1'b0;
               tok_value <= '0;
               tok_index <= '0;
               tok_last  <= 1'b0;
            end
            if (rx_valid) begin
               case (state)
                  S_IDLE: begin
                     if (is_digit) begin
                        acc   <= acc_step('0, digit);
                        dcnt  <= DC_W'(1);
                        neg   <= 1'b0;
                        state <= S_DIGIT;
                     end else if (is_minus && (SIGNED_EN != 0)) begin
                        neg   <= 1'b1;
                        state <= S_SIGN;
                     end else if (is_nl) begin
                        line_done <= 1'b1;
                        idx       <= '0;
                     end else if (!is_delim) begin
                        err_char <= 1'b1;
                        state    <= S_SKIP;
                     end
                  end
                  S_SIGN: begin
                     if (is_digit) begin
                        acc   <= acc_step('0, digit);
                        dcnt  <= DC_W'(1);
                        state <= S_DIGIT;
                     end else if (is_nl) begin
                        err_char  <= 1'b1;
                        line_done <= 1'b1;
                        idx       <= '0;
                        state     <= S_IDLE;
                     end else begin
                        err_char <= 1'b1;
                        state    <= S_SKIP;
                     end
                  end
                  S_DIGIT: begin
                     if (is_digit) begin
                        // Digits past MAX_DIGITS only push the value to saturation.
                        if (dcnt == DC_LIM) begin
                           acc <= LIMIT;
                        end else begin
                           acc  <= acc_step(acc, digit);
                           dcnt <= dcnt + DC_W'(1);
                        end
                     end else if (is_delim || is_nl) begin
                        if (idx == IDX_LIM) begin
                           err_char <= 1'b1;
                           state    <= is_nl ? S_IDLE : S_SKIP;
                        end else begin
                           idx   <= idx + (IDX_W+1)'(1);
                           state <= S_IDLE;
                           // A slot freed by an accept this cycle can take the new token.
                           if (!tok_valid || tok_ready) begin
                              tok_value <= clamp_res[DATA_W-1:0];
                              tok_index <= idx[IDX_W-1:0];
                              tok_last  <= is_nl;
                              tok_valid <= 1'b1;
                              err_range <= clamp_res[DATA_W];
                           end else begin
                              err_ovr <= 1'b1;
                           end
                        end
                        if (is_nl) begin
                           line_done <= 1'b1;
                           idx       <= '0;
                        end
                     end else begin
                        err_char <= 1'b1;
                        state    <= S_SKIP;
                     end
                  end
                  default: begin
                     if (is_nl) begin
                        line_done <= 1'b1;
                        idx       <= '0;
                        state     <= S_IDLE;
                     end
                  end
               endcase
            end
         end
      end
   end

endmodule
